osc_group_scheduler: RTL
========================

# osc_group_scheduler

Shares the two-group 2-bit oscillator core between two requesters. Each requester asks for the oscillator to run in a chosen group (group 0: 00↔01, group 1: 10↔11) for a programmed dwell. The scheduler arbitrates round-robin and issues the single-cycle group-switch control to the core when needed. It times the dwell and signals completion, and is the sole driver of the core's mode input.

## Interface
Parameters:
- DWELL_W, 8, width of the dwell count per request.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  2  request per requester; level, held high until `done` for that requester.
- req_grp  in  2  requested group per requester; bit i belongs to requester i; sampled at grant.
- req_dwell0  in  DWELL_W  dwell for requester 0; sampled at grant.
- req_dwell1  in  DWELL_W  dwell for requester 1; sampled at grant.
- gnt  out  2  one-hot grant; high from grant edge until end of DWELL.
- done  out  2  one-cycle completion pulse per requester.
- busy  out  1  high whenever FSM is not IDLE.
- osc_a  out  1  mode input currently driven to the core; 1 = switch group, 0 = oscillate in group.
- osc_state  out  2  current core state; bit 1 is the group.

## Operation
- Core (sub-module) behaviour:
  - A=0: toggles bit 0 every cycle.
  - A=1: toggles bit 1 and keeps bit 0, i.e. 00→10, 01→11, 10→00, 11→01.
- FSM states: IDLE, SWITCH, DWELL, DONE.
- IDLE:
  - osc_a=0.
  - If any req bit is high, select the winner by round-robin.
  - On the edge: latch the winner index, `req_grp[win]` and the winner's dwell into `cnt`; set `gnt[win]`; go to SWITCH.
- Round-robin:
  - `rr_ptr` gives priority to the requester it names; reset value 0.
  - On each grant, `rr_ptr` ← the other requester.
  - If only one requester is high, it wins regardless of `rr_ptr`.
- SWITCH (exactly 1 cycle):
  - osc_a = (latched group ≠ osc_state[1]).
  - Next edge → DWELL.
  - After that edge, osc_state[1] equals the requested group.
- DWELL:
  - osc_a=0; the core oscillates within the group.
  - cnt decrements each cycle.
  - Exit to DONE on the edge where cnt==0, so DWELL lasts dwell+1 cycles (dwell=0 → 1 cycle).
- Early release: if `req[win]` drops during SWITCH or DWELL, go to DONE on the next edge; done still pulses.
- DONE (1 cycle):
  - gnt=0, done[win]=1, osc_a=0.
  - Next edge → IDLE.
  - A requester still asserting req in IDLE may be granted again, subject to round-robin.
- Simultaneous req[0] and req[1] in IDLE: `rr_ptr` decides; the loser waits with req held.
- req changes while busy are ignored except the early-release rule above.
- Reset:
  - Outputs: gnt=00, done=00, busy=0, osc_a=0, osc_state=00.
  - State: FSM=IDLE, rr_ptr=0, cnt=0.
  - Reset asserted mid-grant aborts without a done pulse.

## Timing
- Request to grant: req high at cycle k in IDLE → gnt visible after edge k+1.
- Switch timing:
  - osc_a is combinational from FSM state, latched group and osc_state[1].
  - It is high only during the SWITCH cycle.
  - The group flip is visible one edge after SWITCH.
- Full transaction (no early release): 1 (SWITCH) + dwell+1 (DWELL) + 1 (DONE) cycles after grant, then IDLE.
- Back-to-back grants: minimum IDLE gap of 1 cycle between DONE and the next SWITCH.
- Width rules:
  - cnt is DWELL_W bits and decrements without wrap; 0 is the terminal value.
  - osc_state is exactly 2 bits with no illegal values; the core default maps to 00.

## Structure
- Shared package `osc_pkg`:
  - group constants GRP0=0, GRP1=1;
  - core state encodings S00..S11;
  - FSM state enum (IDLE, SWITCH, DWELL, DONE, 2-bit).
- Sub-module `osc_group_core`: the 2-bit oscillator (clk, rst, a, state), instantiated once; reset state 00.
- Top: FSM, round-robin pointer, dwell counter, latched winner/group.

## Test plan
- Reset then req=01, req_grp=00, dwell0=3:
  - gnt=01 one cycle later; osc_a stays 0;
  - DWELL lasts 4 cycles with osc_state alternating within 00/01;
  - done=01 pulse, then IDLE.
- From osc_state=01, req=01, req_grp[0]=1, dwell0=0:
  - osc_a=1 for exactly one cycle; osc_state goes 01→11;
  - DWELL lasts 1 cycle; done pulses.
- req=11 held continuously, groups 0 and 1, dwell 2 each:
  - grants alternate 01,10,01;
  - each switch pulses osc_a once; osc_state[1] matches the granted group throughout DWELL.
- req[1] granted with dwell1=200; drop req[1] after 5 DWELL cycles → DONE next edge, done=10, gnt=00.
- Assert rst during DWELL → immediately gnt=00, done=00, osc_state=00, busy=0; no done pulse after release.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared constants and types for the oscillator group scheduler and its core.
package osc_pkg;

    localparam logic GRP0 = 1'b0;
    localparam logic GRP1 = 1'b1;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        DWELL  = 2'd2,
        DONE   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/osc_group_core.sv
// Two-group 2-bit oscillator: a=0 toggles bit 0 within the group, a=1 flips the group bit.
module osc_group_core
    import osc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    output logic [1:0] state
);

    logic [1:0] state_nxt;

    always_comb begin
        state_nxt = S00;
        case (state)
            S00:     state_nxt = a ? S10 : S01;
            S01:     state_nxt = a ? S11 : S00;
            S10:     state_nxt = a ? S00 : S11;
            S11:     state_nxt = a ? S01 : S10;
            default: state_nxt = S00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S00;
        else     state <= state_nxt;
    end

endmodule

// File: rtl/osc_group_scheduler.sv
// Round-robin sharing of the oscillator core between two requesters, with group switch and timed dwell.
//   state  | meaning
//   IDLE   | no grant; pick a winner when any req is high
//   SWITCH | one cycle; pulse osc_a if the core is in the wrong group
//   DWELL  | core oscillates in the granted group while cnt counts down
//   DONE   | one-cycle done pulse to the winner, grant dropped
module osc_group_scheduler
    import osc_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [1:0]         req_grp,
    input  logic [DWELL_W-1:0] req_dwell0,
    input  logic [DWELL_W-1:0] req_dwell1,
    output logic [1:0]         gnt,
    output logic [1:0]         done,
    output logic               busy,
    output logic               osc_a,
    output logic [1:0]         osc_state
);

    sched_state_t       state, state_nxt;
    logic               win;
    logic               grp;
    logic               rr_ptr;
    logic [DWELL_W-1:0] cnt;
    logic               sel;
    logic               grant;
    logic               released;

    // A lone requester wins outright; rr_ptr only breaks ties.
    always_comb begin
        sel = rr_ptr;
        if (req == 2'b01)      sel = 1'b0;
        else if (req == 2'b10) sel = 1'b1;
    end

    assign grant    = (state == IDLE) && (req != 2'b00);
    assign released = !req[win];
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        osc_a     = 1'b0;
        gnt       = 2'b00;
        done      = 2'b00;
        case (state)
            IDLE: begin
                if (req != 2'b00) state_nxt = SWITCH;
            end
            SWITCH: begin
                osc_a     = (grp != osc_state[1]);
                gnt       = win ? 2'b10 : 2'b01;
                state_nxt = released ? DONE : DWELL;
            end
            DWELL: begin
                gnt = win ? 2'b10 : 2'b01;
                if (released || cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                done      = win ? 2'b10 : 2'b01;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win    <= 1'b0;
            grp    <= GRP0;
            rr_ptr <= 1'b0;
            cnt    <= '0;
        end else if (grant) begin
            win    <= sel;
            grp    <= req_grp[sel];
            rr_ptr <= ~sel;
            cnt    <= sel ? req_dwell1 : req_dwell0;
        end else if (state == DWELL && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    osc_group_core u_core (
        .clk   (clk),
        .rst   (rst),
        .a     (osc_a),
        .state (osc_state)
    );

endmodule
